// File: rtl/binary_mul_7_share_arb_if.sv
// Request/response channels between client blocks and the shared 7x7 multiplier arbiter.
// master = client side, slave = arbiter side.
interface binary_mul_7_share_arb_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [7*NUM_REQ-1:0] req_a;
  logic [7*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 rsp_valid;
  logic [ID_W-1:0]      rsp_id;
  logic [13:0]          rsp_p;
  logic                 rsp_ready;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_p
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_p
  );
endinterface

// File: rtl/binary_mul_7_share_arb.sv
// Round-robin sequencer sharing one registered 7x7 multiplier among NUM_REQ requesters.
// Optional macro BMUL_ARB_ZERO_BYPASS_EN: ops with a zero operand skip the multiplier.
module binary_mul_7_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  binary_mul_7_share_arb_if.slave       bus,
  output logic [6:0]                    mul_a,
  output logic [6:0]                    mul_b,
  output logic                          mul_en,
  input  logic [13:0]                   mul_p,
  output logic                          busy
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [CNT_W-1:0] wcnt;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] scan;
  logic            grant_vld;
  logic [6:0]      sel_a;
  logic [6:0]      sel_b;
  logic            accept;

  // Scan from farthest to nearest so the requester closest after rr_ptr wins.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    scan      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      scan = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (bus.req_valid[scan]) begin
        grant     = scan;
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == ID_W'(i)) begin
        sel_a = bus.req_a[7*i +: 7];
        sel_b = bus.req_b[7*i +: 7];
      end
    end
  end

  assign accept = (state == IDLE) && grant_vld;

  // Held at zero during reset so no grant is visible before the FSM is live.
  always_comb begin
    bus.req_ready = '0;
    if (rst_n && accept) bus.req_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= ID_W'(NUM_REQ - 1);
      wcnt          <= '0;
      mul_a         <= '0;
      mul_b         <= '0;
      mul_en        <= 1'b0;
      busy          <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_p     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rr_ptr     <= grant;
            bus.rsp_id <= grant;
            busy       <= 1'b1;
`ifdef BMUL_ARB_ZERO_BYPASS_EN
            if (sel_a == 7'd0 || sel_b == 7'd0) begin
              bus.rsp_p     <= '0;
              bus.rsp_valid <= 1'b1;
              state         <= RESP;
            end else begin
              mul_a  <= sel_a;
              mul_b  <= sel_b;
              mul_en <= 1'b1;
              state  <= ISSUE;
            end
`else
            mul_a  <= sel_a;
            mul_b  <= sel_b;
            mul_en <= 1'b1;
            state  <= ISSUE;
`endif
          end
        end
        ISSUE: begin
          mul_en <= 1'b0;
          wcnt   <= CNT_W'(MUL_LAT - 1);
          state  <= WAIT;
        end
        // The product is only trusted in the last WAIT cycle.
        WAIT: begin
          if (wcnt == '0) begin
            bus.rsp_p     <= mul_p;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end else begin
            wcnt <= wcnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
